// File: rtl/game_pkg.sv
// Shared types and constants for the game sequencer and its cursor counters.
package game_pkg;

  typedef enum logic [1:0] {
    MENU  = 2'd0,
    CLEAR = 2'd1,
    PLAY  = 2'd2
  } game_state_e;

  localparam int SIZE_MIN   = 2;
  localparam int SIZE_MAX   = 4;
  localparam int SIZE_RESET = 3;
  localparam int CELL_W     = 5;
  localparam int ADDR_W     = 8;
  localparam int POS_W      = 4;

  // Row-major cell index; the largest board (16x16) exactly fills the address space.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [POS_W-1:0] x,
                                                  input logic [POS_W-1:0] y,
                                                  input logic [4:0]       side);
    return ADDR_W'(y) * ADDR_W'(side) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/game_ctrl_fsm_cursor_wrap_ctr.sv
// One cursor axis: wrapping increment/decrement with opposing requests cancelling.
module cursor_wrap_ctr
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             load0,
  input  logic [POS_W-1:0] limit,
  output logic [POS_W-1:0] pos
);

  logic [POS_W-1:0] pos_q;
  logic [POS_W-1:0] pos_d;

  always_comb begin
    pos_d = pos_q;
    if (load0) begin
      pos_d = '0;
    end else if (inc && !dec) begin
      pos_d = (pos_q >= limit) ? '0 : pos_q + 1'b1;
    end else if (dec && !inc) begin
      pos_d = (pos_q == '0) ? limit : pos_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign pos = pos_q;

endmodule

// File: rtl/game_ctrl_fsm.sv
// Game sequencer: board-size menu, cell RAM clear sweep, and play-mode cursor/digit writes.
module game_ctrl_fsm
  import game_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              key_up,
  input  logic              key_down,
  input  logic              key_left,
  input  logic              key_right,
  input  logic              key_enter,
  input  logic              key_esc,
  input  logic              key_digit_valid,
  input  logic [CELL_W-1:0] key_digit,
  output logic              is_game_on,
  output logic [2:0]        board_size,
  output logic [POS_W-1:0]  cursor_x,
  output logic [POS_W-1:0]  cursor_y,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [CELL_W-1:0] mem_wdata,
  output logic              clear_busy
);

  localparam logic [2:0] SZ_MIN   = 3'(SIZE_MIN);
  localparam logic [2:0] SZ_MAX   = 3'(SIZE_MAX);
  localparam logic [2:0] SZ_RESET = 3'(SIZE_RESET);

  game_state_e       state_q, state_d;
  logic [2:0]        size_q, size_d;
  logic [8:0]        cnt_q, cnt_d;
  logic              is_game_on_q, is_game_on_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [CELL_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              clear_busy_q, clear_busy_d;

  logic [4:0]        side;
  logic [8:0]        cells;
  logic [POS_W-1:0]  limit;
  logic              x_inc, x_dec, y_inc, y_dec, cur_load0;
  logic [POS_W-1:0]  cur_x, cur_y;

  assign side  = 5'(size_q) * 5'(size_q);
  assign cells = 9'(side) * 9'(side);
  assign limit = 4'(side - 5'd1);

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    cnt_d        = cnt_q;
    is_game_on_d = 1'b0;
    clear_busy_d = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    x_inc        = 1'b0;
    x_dec        = 1'b0;
    y_inc        = 1'b0;
    y_dec        = 1'b0;
    cur_load0    = 1'b0;

    case (state_q)
      MENU: begin
        // Enter issues the first clear write right away, so it lands one cycle later.
        if (key_enter) begin
          state_d      = CLEAR;
          cnt_d        = '0;
          mem_we_d     = 1'b1;
          mem_addr_d   = '0;
          mem_wdata_d  = '0;
          clear_busy_d = 1'b1;
        end else if (key_right && !key_left && size_q < SZ_MAX) begin
          size_d = size_q + 3'd1;
        end else if (key_left && !key_right && size_q > SZ_MIN) begin
          size_d = size_q - 3'd1;
        end
      end

      CLEAR: begin
        // cnt_q is the address currently on the write port.
        if (cnt_q == cells - 9'd1) begin
          state_d      = PLAY;
          is_game_on_d = 1'b1;
          cur_load0    = 1'b1;
        end else begin
          cnt_d        = cnt_q + 9'd1;
          mem_we_d     = 1'b1;
          mem_addr_d   = cnt_d[ADDR_W-1:0];
          mem_wdata_d  = '0;
          clear_busy_d = 1'b1;
        end
      end

      PLAY: begin
        is_game_on_d = 1'b1;
        if (key_esc) begin
          state_d      = MENU;
          is_game_on_d = 1'b0;
        end else if (key_digit_valid && key_digit <= side) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cell_addr(cur_x, cur_y, side);
          mem_wdata_d = key_digit;
        end else begin
          x_inc = key_right;
          x_dec = key_left;
          y_inc = key_down;
          y_dec = key_up;
        end
      end

      default: begin
        state_d = MENU;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= MENU;
      size_q       <= SZ_RESET;
      cnt_q        <= '0;
      is_game_on_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      clear_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      cnt_q        <= cnt_d;
      is_game_on_q <= is_game_on_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      clear_busy_q <= clear_busy_d;
    end
  end

  cursor_wrap_ctr u_cur_x (
    .clk   (clk),
    .rst   (rst),
    .inc   (x_inc),
    .dec   (x_dec),
    .load0 (cur_load0),
    .limit (limit),
    .pos   (cur_x)
  );

  cursor_wrap_ctr u_cur_y (
    .clk   (clk),
    .rst   (rst),
    .inc   (y_inc),
    .dec   (y_dec),
    .load0 (cur_load0),
    .limit (limit),
    .pos   (cur_y)
  );

  assign is_game_on = is_game_on_q;
  assign board_size = size_q;
  assign cursor_x   = cur_x;
  assign cursor_y   = cur_y;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign clear_busy = clear_busy_q;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Self-checking bench for game_ctrl_fsm: directed scenarios plus randomized menu/play traffic.
module tb_game_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_up, key_down, key_left, key_right, key_enter, key_esc, key_digit_valid;
  logic [4:0] key_digit;
  logic       is_game_on;
  logic [2:0] board_size;
  logic [3:0] cursor_x, cursor_y;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [4:0] mem_wdata;
  logic       clear_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: board size and cursor as plain integers.
  int m_size;
  int m_x;
  int m_y;

  always #5 clk = ~clk;

  game_ctrl_fsm dut (
    .clk             (clk),
    .rst             (rst),
    .key_up          (key_up),
    .key_down        (key_down),
    .key_left        (key_left),
    .key_right       (key_right),
    .key_enter       (key_enter),
    .key_esc         (key_esc),
    .key_digit_valid (key_digit_valid),
    .key_digit       (key_digit),
    .is_game_on      (is_game_on),
    .board_size      (board_size),
    .cursor_x        (cursor_x),
    .cursor_y        (cursor_y),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .clear_busy      (clear_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic u, input logic d, input logic l, input logic r,
                       input logic en, input logic esc, input logic dv, input logic [4:0] dig);
    key_up = u; key_down = d; key_left = l; key_right = r;
    key_enter = en; key_esc = esc; key_digit_valid = dv; key_digit = dig;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic press(input logic u, input logic d, input logic l, input logic r,
                       input logic en, input logic esc, input logic dv, input logic [4:0] dig);
    drive(u, d, l, r, en, esc, dv, dig);
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    m_size = 3; m_x = 0; m_y = 0;
    n_checks++;
    if (board_size !== 3'd3) begin
      n_fail++; $display("FAIL reset_board_size: got %0d expected 3", board_size);
    end
    n_checks++;
    if ({cursor_x, cursor_y} !== 8'h00) begin
      n_fail++; $display("FAIL reset_cursor: got (%0d,%0d) expected (0,0)", cursor_x, cursor_y);
    end
    n_checks++;
    if ({is_game_on, mem_we, clear_busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got on=%0b we=%0b busy=%0b expected all 0", is_game_on, mem_we, clear_busy);
    end
    n_checks++;
    if ({mem_addr, mem_wdata} !== 13'd0) begin
      n_fail++; $display("FAIL reset_mem_bus: got addr=%0d data=%0d expected 0/0", mem_addr, mem_wdata);
    end
    $display("test_reset: done");
  endtask

  task automatic test_menu_size();
    int exp_r[3] = '{4, 4, 4};
    int exp_l[4] = '{3, 2, 2, 2};
    logic [6:0] rk;
    for (int i = 0; i < 3; i++) begin
      press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
      n_checks++;
      if (int'(board_size) != exp_r[i]) begin
        n_fail++; $display("FAIL menu_right_%0d: got %0d expected %0d", i, board_size, exp_r[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      press(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      n_checks++;
      if (int'(board_size) != exp_l[i]) begin
        n_fail++; $display("FAIL menu_left_%0d: got %0d expected %0d", i, board_size, exp_l[i]);
      end
    end
    press(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    n_checks++;
    if (board_size !== 3'd2) begin
      n_fail++; $display("FAIL menu_left_right: got %0d expected 2", board_size);
    end
    m_size = 2;
    // Random menu traffic without enter: only left/right may change the size.
    for (int i = 0; i < 40; i++) begin
      rk = 7'($urandom);
      drive(rk[0], rk[1], rk[2], rk[3], 1'b0, rk[4], rk[5], 5'($urandom));
      if (rk[3] && !rk[2]) m_size = (m_size + 1 > 4) ? 4 : m_size + 1;
      if (rk[2] && !rk[3]) m_size = (m_size - 1 < 2) ? 2 : m_size - 1;
      tick();
      n_checks++;
      if (int'(board_size) != m_size) begin
        n_fail++; $display("FAIL menu_rand_size_%0d: got %0d expected %0d", i, board_size, m_size);
      end
      n_checks++;
      if ({is_game_on, mem_we, clear_busy} !== 3'b000) begin
        n_fail++; $display("FAIL menu_rand_flags_%0d: got on=%0b we=%0b busy=%0b expected 000", i, is_game_on, mem_we, clear_busy);
      end
    end
    idle();
    $display("test_menu_size: board_size now %0d", m_size);
  endtask

  task automatic set_size(input int target);
    while (m_size != target) begin
      if (m_size < target) begin
        press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0); m_size++;
      end else begin
        press(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0); m_size--;
      end
    end
    n_checks++;
    if (int'(board_size) != target) begin
      n_fail++; $display("FAIL set_size: got %0d expected %0d", board_size, target);
    end
  endtask

  // Enter from MENU and follow the full clear sweep into PLAY.
  task automatic test_clear();
    int cells;
    logic [6:0] rk;
    cells = m_size * m_size * m_size * m_size;
    rk = 7'($urandom);
    drive(1'b0, 1'b0, rk[0], rk[1], 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    for (int k = 0; k < cells; k++) begin
      n_checks++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'(k), 5'd0}) begin
        n_fail++; $display("FAIL clear_write_%0d: got we=%0b addr=%0d data=%0d expected we=1 addr=%0d data=0", k, mem_we, mem_addr, mem_wdata, k);
      end
      n_checks++;
      if ({clear_busy, is_game_on} !== 2'b10) begin
        n_fail++; $display("FAIL clear_flags_%0d: got busy=%0b on=%0b expected busy=1 on=0", k, clear_busy, is_game_on);
      end
      n_checks++;
      if (int'(board_size) != m_size) begin
        n_fail++; $display("FAIL clear_size_frozen_%0d: got %0d expected %0d", k, board_size, m_size);
      end
      rk = 7'($urandom);
      drive(rk[0], rk[1], rk[2], rk[3], rk[4], rk[5], rk[6], 5'($urandom));
      tick();
    end
    idle();
    m_x = 0; m_y = 0;
    n_checks++;
    if ({is_game_on, clear_busy, mem_we} !== 3'b100) begin
      n_fail++; $display("FAIL clear_end: got on=%0b busy=%0b we=%0b expected on=1 busy=0 we=0", is_game_on, clear_busy, mem_we);
    end
    n_checks++;
    if ({cursor_x, cursor_y} !== 8'h00) begin
      n_fail++; $display("FAIL clear_end_cursor: got (%0d,%0d) expected (0,0)", cursor_x, cursor_y);
    end
    $display("test_clear: size %0d swept %0d cells", m_size, cells);
  endtask

  task automatic test_play_directed3();
    press(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    n_checks++;
    if ({cursor_x, cursor_y} !== {4'd8, 4'd0}) begin
      n_fail++; $display("FAIL play_left_wrap: got (%0d,%0d) expected (8,0)", cursor_x, cursor_y);
    end
    press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    n_checks++;
    if ({cursor_x, cursor_y} !== {4'd8, 4'd8}) begin
      n_fail++; $display("FAIL play_up_wrap: got (%0d,%0d) expected (8,8)", cursor_x, cursor_y);
    end
    press(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5);
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'd80, 5'd5}) begin
      n_fail++; $display("FAIL play_digit5: got we=%0b addr=%0d data=%0d expected we=1 addr=80 data=5", mem_we, mem_addr, mem_wdata);
    end
    tick();
    n_checks++;
    if (mem_we !== 1'b0) begin
      n_fail++; $display("FAIL play_we_one_cycle: got we=%0b expected 0", mem_we);
    end
    press(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd10);
    n_checks++;
    if ({mem_we, is_game_on} !== 2'b01) begin
      n_fail++; $display("FAIL play_digit10: got we=%0b on=%0b expected we=0 on=1", mem_we, is_game_on);
    end
    m_x = 8; m_y = 8;
    $display("test_play_directed3: write addr 80 data 5");
  endtask

  task automatic test_play_random(input int n);
    int side, dx, dy, exp_addr;
    logic [6:0] rk;
    logic       dv, exp_we;
    logic [4:0] dig;
    for (int i = 0; i < n; i++) begin
      side = m_size * m_size;
      rk = 7'($urandom);
      dv = ($urandom_range(0, 3) == 0);
      dig = 5'($urandom_range(0, (side + 4 > 31) ? 31 : side + 4));
      drive(rk[0], rk[1], rk[2], rk[3], rk[4], 1'b0, dv, dig);
      exp_we = dv && (int'(dig) <= side);
      exp_addr = m_y * side + m_x;
      if (!exp_we) begin
        dx = int'(rk[3]) - int'(rk[2]);
        dy = int'(rk[1]) - int'(rk[0]);
        m_x = (m_x + dx + side) % side;
        m_y = (m_y + dy + side) % side;
      end
      tick();
      n_checks++;
      if (exp_we) begin
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'(exp_addr), dig}) begin
          n_fail++; $display("FAIL play_rand_write_%0d: got we=%0b addr=%0d data=%0d expected we=1 addr=%0d data=%0d", i, mem_we, mem_addr, mem_wdata, exp_addr, dig);
        end else begin
          $display("play write: addr=%0d data=%0d", mem_addr, mem_wdata);
        end
      end else if (mem_we !== 1'b0) begin
        n_fail++; $display("FAIL play_rand_nowrite_%0d: got we=%0b expected 0", i, mem_we);
      end
      n_checks++;
      if ({cursor_x, cursor_y, is_game_on} !== {4'(m_x), 4'(m_y), 1'b1}) begin
        n_fail++; $display("FAIL play_rand_cursor_%0d: got (%0d,%0d) on=%0b expected (%0d,%0d) on=1", i, cursor_x, cursor_y, is_game_on, m_x, m_y);
      end
    end
    idle();
  endtask

  task automatic test_esc_digit();
    press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1);
    n_checks++;
    if ({is_game_on, mem_we} !== 2'b00) begin
      n_fail++; $display("FAIL esc_digit: got on=%0b we=%0b expected on=0 we=0", is_game_on, mem_we);
    end
    n_checks++;
    if ({cursor_x, cursor_y} !== {4'(m_x), 4'(m_y)}) begin
      n_fail++; $display("FAIL esc_cursor_hold: got (%0d,%0d) expected (%0d,%0d)", cursor_x, cursor_y, m_x, m_y);
    end
    $display("test_esc_digit: back in menu");
  endtask

  task automatic test_size2();
    set_size(2);
    test_clear();
    press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    n_checks++;
    if ({cursor_x, cursor_y} !== {4'd1, 4'd2}) begin
      n_fail++; $display("FAIL size2_cursor_setup: got (%0d,%0d) expected (1,2)", cursor_x, cursor_y);
    end
    press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3);
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata, cursor_x, cursor_y} !== {1'b1, 8'd9, 5'd3, 4'd1, 4'd2}) begin
      n_fail++; $display("FAIL size2_digit_move: got we=%0b addr=%0d data=%0d cur=(%0d,%0d) expected we=1 addr=9 data=3 cur=(1,2)", mem_we, mem_addr, mem_wdata, cursor_x, cursor_y);
    end
    press(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    n_checks++;
    if ({mem_we, cursor_x, cursor_y} !== {1'b0, 4'd2, 4'd3}) begin
      n_fail++; $display("FAIL size2_diag: got we=%0b cur=(%0d,%0d) expected we=0 cur=(2,3)", mem_we, cursor_x, cursor_y);
    end
    m_x = 2; m_y = 3;
    $display("test_size2: write addr 9 data 3, cursor (2,3)");
  endtask

  task automatic test_reset_mid_play();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    m_size = 3; m_x = 0; m_y = 0;
    n_checks++;
    if ({is_game_on, mem_we, clear_busy, board_size, cursor_x, cursor_y} !== {3'b000, 3'd3, 8'h00}) begin
      n_fail++; $display("FAIL reset_mid_play: got on=%0b we=%0b busy=%0b size=%0d cur=(%0d,%0d) expected 0/0/0/3/(0,0)", is_game_on, mem_we, clear_busy, board_size, cursor_x, cursor_y);
    end
    $display("test_reset_mid_play: done");
  endtask

  task automatic test_reset_mid_clear();
    set_size(4);
    press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    for (int k = 0; k < 40; k++) tick();
    n_checks++;
    if ({mem_we, mem_addr, clear_busy} !== {1'b1, 8'd40, 1'b1}) begin
      n_fail++; $display("FAIL reset_clear_pre: got we=%0b addr=%0d busy=%0b expected we=1 addr=40 busy=1", mem_we, mem_addr, clear_busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_size = 3;
    n_checks++;
    if ({clear_busy, mem_we, is_game_on, board_size} !== {3'b000, 3'd3}) begin
      n_fail++; $display("FAIL reset_mid_clear: got busy=%0b we=%0b on=%0b size=%0d expected 0/0/0/3", clear_busy, mem_we, is_game_on, board_size);
    end
    tick();
    n_checks++;
    if ({clear_busy, mem_we} !== 2'b00) begin
      n_fail++; $display("FAIL reset_clear_abandoned: got busy=%0b we=%0b expected 0/0", clear_busy, mem_we);
    end
    press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    n_checks++;
    if (board_size !== 3'd4) begin
      n_fail++; $display("FAIL reset_clear_menu_live: got %0d expected 4", board_size);
    end
    m_size = 4;
    $display("test_reset_mid_clear: done");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle();
    test_reset();
    test_menu_size();
    set_size(3);
    test_clear();
    test_play_directed3();
    test_play_random(150);
    test_esc_digit();
    set_size(4);
    test_clear();
    test_play_random(80);
    press(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
    n_checks++;
    if (is_game_on !== 1'b0) begin
      n_fail++; $display("FAIL esc_to_menu: got on=%0b expected 0", is_game_on);
    end
    test_size2();
    test_play_random(60);
    test_reset_mid_play();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
